// File: rtl/alu_share_arbiter_if.sv
// Requester-side handshake bundle for alu_share_arbiter: two request ports
// and their one-entry response slots. The arbiter uses the slave modport.
interface alu_share_arbiter_if #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
);
  logic            req_valid_0;
  logic            req_valid_1;
  logic            req_ready_0;
  logic            req_ready_1;
  logic [OPW-1:0]  req_op_0;
  logic [OPW-1:0]  req_op_1;
  logic [XLEN-1:0] req_a_0;
  logic [XLEN-1:0] req_a_1;
  logic [XLEN-1:0] req_b_0;
  logic [XLEN-1:0] req_b_1;
  logic            rsp_valid_0;
  logic            rsp_valid_1;
  logic            rsp_ready_0;
  logic            rsp_ready_1;
  logic [XLEN-1:0] rsp_result_0;
  logic [XLEN-1:0] rsp_result_1;
  logic            rsp_zero_0;
  logic            rsp_zero_1;

  modport master (
    output req_valid_0, req_valid_1, req_op_0, req_op_1,
           req_a_0, req_a_1, req_b_0, req_b_1,
           rsp_ready_0, rsp_ready_1,
    input  req_ready_0, req_ready_1,
           rsp_valid_0, rsp_valid_1, rsp_result_0, rsp_result_1,
           rsp_zero_0, rsp_zero_1
  );

  modport slave (
    input  req_valid_0, req_valid_1, req_op_0, req_op_1,
           req_a_0, req_a_1, req_b_0, req_b_1,
           rsp_ready_0, rsp_ready_1,
    output req_ready_0, req_ready_1,
           rsp_valid_0, rsp_valid_1, rsp_result_0, rsp_result_1,
           rsp_zero_0, rsp_zero_1
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters with per-port result slots.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins) instead of round-robin.
module alu_share_arbiter #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_share_arbiter_if.slave  bus,
  output logic [OPW-1:0]      alu_ctrl,
  output logic [XLEN-1:0]     alu_a,
  output logic [XLEN-1:0]     alu_b,
  input  logic [XLEN-1:0]     alu_result,
  input  logic                alu_zero
);

  logic            w_free_0;
  logic            w_free_1;
  logic            w_elig_0;
  logic            w_elig_1;
  logic            w_grant_0;
  logic            w_grant_1;
  logic            r_rsp_valid_0;
  logic            r_rsp_valid_1;
  logic [XLEN-1:0] r_rsp_result_0;
  logic [XLEN-1:0] r_rsp_result_1;
  logic            r_rsp_zero_0;
  logic            r_rsp_zero_1;

  // A slot may be refilled in the same cycle it is drained.
  assign w_free_0 = !r_rsp_valid_0 || bus.rsp_ready_0;
  assign w_free_1 = !r_rsp_valid_1 || bus.rsp_ready_1;
  assign w_elig_0 = bus.req_valid_0 && w_free_0;
  assign w_elig_1 = bus.req_valid_1 && w_free_1;

`ifndef ALU_ARB_FIXED_PRIO_EN
  typedef enum logic {LAST_P0 = 1'b0, LAST_P1 = 1'b1} last_e;
  last_e r_last;
  last_e w_last_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= LAST_P1;
    end else begin
      r_last <= w_last_nxt;
    end
  end

  always_comb begin
    w_last_nxt = r_last;
    if (w_grant_0) begin
      w_last_nxt = LAST_P0;
    end else if (w_grant_1) begin
      w_last_nxt = LAST_P1;
    end else begin
      w_last_nxt = r_last;
    end
  end
`endif

  always_comb begin
    w_grant_0 = 1'b0;
    w_grant_1 = 1'b0;
    if (w_elig_0 && w_elig_1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_grant_0 = 1'b1;
`else
      if (r_last == LAST_P1) begin
        w_grant_0 = 1'b1;
      end else begin
        w_grant_1 = 1'b1;
      end
`endif
    end else if (w_elig_0) begin
      w_grant_0 = 1'b1;
    end else if (w_elig_1) begin
      w_grant_1 = 1'b1;
    end else begin
      w_grant_0 = 1'b0;
      w_grant_1 = 1'b0;
    end
  end

  assign bus.req_ready_0 = w_grant_0;
  assign bus.req_ready_1 = w_grant_1;

  // Idle drives an add of zeros so the ALU inputs never float.
  always_comb begin
    alu_ctrl = {OPW{1'b0}};
    alu_a    = {XLEN{1'b0}};
    alu_b    = {XLEN{1'b0}};
    if (w_grant_0) begin
      alu_ctrl = bus.req_op_0;
      alu_a    = bus.req_a_0;
      alu_b    = bus.req_b_0;
    end else if (w_grant_1) begin
      alu_ctrl = bus.req_op_1;
      alu_a    = bus.req_a_1;
      alu_b    = bus.req_b_1;
    end else begin
      alu_ctrl = {OPW{1'b0}};
      alu_a    = {XLEN{1'b0}};
      alu_b    = {XLEN{1'b0}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid_0  <= 1'b0;
      r_rsp_result_0 <= {XLEN{1'b0}};
      r_rsp_zero_0   <= 1'b0;
    end else if (w_grant_0) begin
      r_rsp_valid_0  <= 1'b1;
      r_rsp_result_0 <= alu_result;
      r_rsp_zero_0   <= alu_zero;
    end else if (bus.rsp_ready_0) begin
      r_rsp_valid_0  <= 1'b0;
    end else begin
      r_rsp_valid_0  <= r_rsp_valid_0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid_1  <= 1'b0;
      r_rsp_result_1 <= {XLEN{1'b0}};
      r_rsp_zero_1   <= 1'b0;
    end else if (w_grant_1) begin
      r_rsp_valid_1  <= 1'b1;
      r_rsp_result_1 <= alu_result;
      r_rsp_zero_1   <= alu_zero;
    end else if (bus.rsp_ready_1) begin
      r_rsp_valid_1  <= 1'b0;
    end else begin
      r_rsp_valid_1  <= r_rsp_valid_1;
    end
  end

  assign bus.rsp_valid_0  = r_rsp_valid_0;
  assign bus.rsp_valid_1  = r_rsp_valid_1;
  assign bus.rsp_result_0 = r_rsp_result_0;
  assign bus.rsp_result_1 = r_rsp_result_1;
  assign bus.rsp_zero_0   = r_rsp_zero_0;
  assign bus.rsp_zero_1   = r_rsp_zero_1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed + random bench for alu_share_arbiter against a per-cycle reference model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        alu_zero;

  alu_share_arbiter_if #(.XLEN(32), .OPW(4)) bus ();

  alu_share_arbiter #(.XLEN(32), .OPW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_ctrl   (alu_ctrl),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  int total = 0;
  int bad   = 0;

  logic        in_v  [2];
  logic        in_r  [2];
  logic [3:0]  in_op [2];
  logic [31:0] in_a  [2];
  logic [31:0] in_b  [2];

  logic        m_valid [2];
  logic [31:0] m_res   [2];
  logic        m_zero  [2];
  int          m_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:    return a << b[4:0];
      4'd7:    return a >> b[4:0];
      4'd8:    return $unsigned($signed(a) >>> b[4:0]);
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return a ^ ~b;
    endcase
  endfunction

  // Stand-in for the external combinational ALU.
  always_comb begin
    alu_result = ref_alu(alu_ctrl, alu_a, alu_b);
    alu_zero   = (alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply();
    bus.req_valid_0 = in_v[0];  bus.req_valid_1 = in_v[1];
    bus.rsp_ready_0 = in_r[0];  bus.rsp_ready_1 = in_r[1];
    bus.req_op_0    = in_op[0]; bus.req_op_1    = in_op[1];
    bus.req_a_0     = in_a[0];  bus.req_a_1     = in_a[1];
    bus.req_b_0     = in_b[0];  bus.req_b_1     = in_b[1];
  endtask

  task automatic set_port(input int p, input logic v, input logic r, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
    in_v[p] = v; in_r[p] = r; in_op[p] = op; in_a[p] = a; in_b[p] = b;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 1'b0;
      m_res[i]   = 32'd0;
      m_zero[i]  = 1'b0;
    end
    m_last = 1;
  endtask

  // Called at a falling edge: drive, check grant/ALU mux, clock, check slots.
  task automatic step();
    int          g;
    logic        e0;
    logic        e1;
    logic [31:0] er;
    apply();
    #1;
    e0 = in_v[0] && (!m_valid[0] || in_r[0]);
    e1 = in_v[1] && (!m_valid[1] || in_r[1]);
    if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      g = 0;
`else
      g = (m_last == 1) ? 0 : 1;
`endif
    end else if (e0) g = 0;
    else if (e1) g = 1;
    else g = -1;
    chk("req_ready_0", {31'd0, bus.req_ready_0}, {31'd0, (g == 0)});
    chk("req_ready_1", {31'd0, bus.req_ready_1}, {31'd0, (g == 1)});
    if (g < 0) begin
      chk("alu_ctrl_idle", {28'd0, alu_ctrl}, 32'd0);
      chk("alu_a_idle", alu_a, 32'd0);
      chk("alu_b_idle", alu_b, 32'd0);
      er = 32'd0;
    end else begin
      chk("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, in_op[g]});
      chk("alu_a", alu_a, in_a[g]);
      chk("alu_b", alu_b, in_b[g]);
      er = ref_alu(in_op[g], in_a[g], in_b[g]);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (g == i) begin
        m_valid[i] = 1'b1;
        m_res[i]   = er;
        m_zero[i]  = (er == 32'd0);
      end else if (in_r[i]) begin
        m_valid[i] = 1'b0;
      end
    end
    if (g >= 0) m_last = g;
    chk("rsp_valid_0", {31'd0, bus.rsp_valid_0}, {31'd0, m_valid[0]});
    chk("rsp_valid_1", {31'd0, bus.rsp_valid_1}, {31'd0, m_valid[1]});
    if (m_valid[0]) begin
      chk("rsp_result_0", bus.rsp_result_0, m_res[0]);
      chk("rsp_zero_0", {31'd0, bus.rsp_zero_0}, {31'd0, m_zero[0]});
    end
    if (m_valid[1]) begin
      chk("rsp_result_1", bus.rsp_result_1, m_res[1]);
      chk("rsp_zero_1", {31'd0, bus.rsp_zero_1}, {31'd0, m_zero[1]});
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_port(0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_port(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    apply();
    model_reset();
    #3;
    chk("reset_valid_0", {31'd0, bus.rsp_valid_0}, 32'd0);
    chk("reset_valid_1", {31'd0, bus.rsp_valid_1}, 32'd0);
    chk("reset_result_0", bus.rsp_result_0, 32'd0);
    chk("reset_result_1", bus.rsp_result_1, 32'd0);
    chk("reset_zero_0", {31'd0, bus.rsp_zero_0}, 32'd0);
    chk("reset_zero_1", {31'd0, bus.rsp_zero_1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single add on port 0: 5 + 7 = 12, then drain.
    set_port(0, 1'b1, 1'b0, 4'd0, 32'd5, 32'd7);
    step();
    chk("add_result", bus.rsp_result_0, 32'd12);
    set_port(0, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
    step();

    // Port 1 subtract to zero, held while rsp_ready_1 is low.
    set_port(1, 1'b1, 1'b0, 4'd1, 32'd9, 32'd9);
    step();
    chk("sub_zero_flag", {31'd0, bus.rsp_zero_1}, 32'd1);
    set_port(1, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) step();
    chk("held_result_1", bus.rsp_result_1, 32'd0);
    set_port(1, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
    step();

    // Contention with both consumers always ready.
    for (int i = 0; i < 6; i++) begin
      set_port(0, 1'b1, 1'b1, 4'd0, 32'd100 + 32'(i), 32'd1);
      set_port(1, 1'b1, 1'b1, 4'd2, 32'hF0F0_0000 + 32'(i), 32'hFFFF_00FF);
      step();
    end

    // Backpressure: fill slot 1 and stall it, port 0 keeps flowing.
    set_port(0, 1'b0, 1'b1, 4'd0, 32'd0, 32'd0);
    set_port(1, 1'b1, 1'b0, 4'd4, 32'hA5A5_A5A5, 32'h0000_FFFF);
    step();
    for (int i = 0; i < 4; i++) begin
      set_port(0, 1'b1, 1'b1, 4'd3, 32'(i), 32'h100);
      set_port(1, 1'b1, 1'b0, 4'd7, 32'h8000_0000, 32'(i + 1));
      step();
    end
    set_port(1, 1'b1, 1'b1, 4'd8, 32'h8000_0000, 32'd4);
    step();

    // Idle with slots draining.
    set_port(0, 1'b0, 1'b1, 4'd5, 32'd1, 32'd2);
    set_port(1, 1'b0, 1'b0, 4'd6, 32'd3, 32'd4);
    step();
    step();

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < 2; p++) begin
        in_v[p]  = ($urandom_range(0, 3) != 0);
        in_r[p]  = ($urandom_range(0, 2) != 0);
        in_op[p] = 4'($urandom_range(0, 15));
        in_a[p]  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
        in_b[p]  = ($urandom_range(0, 3) == 0) ? in_a[p] : $urandom;
      end
      step();
    end

    // Asynchronous reset mid-stream with slot 0 full.
    set_port(0, 1'b1, 1'b0, 4'd0, 32'd20, 32'd22);
    set_port(1, 1'b1, 1'b0, 4'd0, 32'd1, 32'd1);
    for (int i = 0; i < 3; i++) step();
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_valid_0", {31'd0, bus.rsp_valid_0}, 32'd0);
    chk("async_valid_1", {31'd0, bus.rsp_valid_1}, 32'd0);
    chk("async_result_0", bus.rsp_result_0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_port(0, 1'b1, 1'b1, 4'd1, 32'd50, 32'd8);
    set_port(1, 1'b1, 1'b1, 4'd0, 32'd60, 32'd9);
    step();
    chk("post_reset_port0_first", bus.rsp_result_0, 32'd42);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
